// File: rtl/texture_sampler.sv
//------------------------------------------------------------------------------
// Module   : texture_sampler
// Purpose  : Three-stage texel fetch pipeline from the texture RAM read port
//            that emits optionally shaded RGB444 pixels. Build macro:
//            TEX_SHADE_EN enables per-pixel brightness scaling.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module texture_sampler #(
  parameter int          ADDR_WIDTH     = 22,
  parameter int          COLOR_WIDTH    = 12,
  parameter int          TILE_BITS      = 4,
  parameter int          ATLAS_COL_BITS = 2,
  parameter logic [11:0] KEY_COLOR      = 12'hF0F
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2*ATLAS_COL_BITS-1:0]   in_tile,
  input  logic [TILE_BITS-1:0]          in_u,
  input  logic [TILE_BITS-1:0]          in_v,
  input  logic [1:0]                    in_shade,
  input  logic                          in_last,
  output logic [ADDR_WIDTH-1:0]         raddr,
  input  logic [COLOR_WIDTH-1:0]        rcolor,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [COLOR_WIDTH-1:0]        out_color,
  output logic                          out_transparent,
  output logic                          out_last
);

  localparam int LIN_W = 2 * TILE_BITS + 2 * ATLAS_COL_BITS;

  logic                   adv;
  logic [LIN_W-1:0]       lin_addr;
  logic [COLOR_WIDTH-1:0] texel;
  logic [COLOR_WIDTH-1:0] shaded;

  logic [ADDR_WIDTH-1:0]  raddr_q, raddr_d;
  logic                   v1_q, v1_d;
  logic                   last1_q, last1_d;
  logic                   v2_q, v2_d;
  logic                   last2_q, last2_d;
  logic                   stall_q, stall_d;
  logic [COLOR_WIDTH-1:0] hold_q, hold_d;
  logic                   out_valid_q, out_valid_d;
  logic [COLOR_WIDTH-1:0] out_color_q, out_color_d;
  logic                   out_transparent_q, out_transparent_d;
  logic                   out_last_q, out_last_d;

`ifdef TEX_SHADE_EN
  logic [1:0]             shade1_q, shade1_d;
  logic [1:0]             shade2_q, shade2_d;

  function automatic logic [3:0] shade_ch(input logic [3:0] c, input logic [1:0] s);
    logic [5:0] prod;
    prod = {2'b00, c} * {3'b000, 3'd4 - {1'b0, s}};
    return prod[5:2];
  endfunction
`else
  logic unused_shade;
  assign unused_shade = ^in_shade;
`endif

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  // Atlas layout: {tile row, v, tile column, u} forms the linear texel index.
  assign lin_addr = {in_tile[2*ATLAS_COL_BITS-1:ATLAS_COL_BITS], in_v,
                     in_tile[ATLAS_COL_BITS-1:0], in_u};

  // After a stalled clock the RAM has already re-read the held raddr, which
  // belongs to the S1 pixel, so the S2 texel comes from the hold register.
  assign texel = stall_q ? hold_q : rcolor;

  always_comb begin
`ifdef TEX_SHADE_EN
    shaded = {shade_ch(texel[11:8], shade2_q),
              shade_ch(texel[7:4],  shade2_q),
              shade_ch(texel[3:0],  shade2_q)};
`else
    shaded = texel;
`endif
  end

  always_comb begin
    raddr_d           = raddr_q;
    v1_d              = v1_q;
    last1_d           = last1_q;
    v2_d              = v2_q;
    last2_d           = last2_q;
    stall_d           = !adv;
    hold_d            = texel;
    out_valid_d       = out_valid_q;
    out_color_d       = out_color_q;
    out_transparent_d = out_transparent_q;
    out_last_d        = out_last_q;
`ifdef TEX_SHADE_EN
    shade1_d          = shade1_q;
    shade2_d          = shade2_q;
`endif
    if (adv) begin
      raddr_d           = ADDR_WIDTH'(lin_addr);
      v1_d              = in_valid;
      last1_d           = in_last;
      v2_d              = v1_q;
      last2_d           = last1_q;
      out_valid_d       = v2_q;
      out_color_d       = shaded;
      out_transparent_d = (texel == KEY_COLOR);
      out_last_d        = last2_q;
`ifdef TEX_SHADE_EN
      shade1_d          = in_shade;
      shade2_d          = shade1_q;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      raddr_q           <= '0;
      v1_q              <= 1'b0;
      last1_q           <= 1'b0;
      v2_q              <= 1'b0;
      last2_q           <= 1'b0;
      stall_q           <= 1'b0;
      hold_q            <= '0;
      out_valid_q       <= 1'b0;
      out_color_q       <= '0;
      out_transparent_q <= 1'b0;
      out_last_q        <= 1'b0;
`ifdef TEX_SHADE_EN
      shade1_q          <= 2'd0;
      shade2_q          <= 2'd0;
`endif
    end else begin
      raddr_q           <= raddr_d;
      v1_q              <= v1_d;
      last1_q           <= last1_d;
      v2_q              <= v2_d;
      last2_q           <= last2_d;
      stall_q           <= stall_d;
      hold_q            <= hold_d;
      out_valid_q       <= out_valid_d;
      out_color_q       <= out_color_d;
      out_transparent_q <= out_transparent_d;
      out_last_q        <= out_last_d;
`ifdef TEX_SHADE_EN
      shade1_q          <= shade1_d;
      shade2_q          <= shade2_d;
`endif
    end
  end

  assign raddr           = raddr_q;
  assign out_valid       = out_valid_q;
  assign out_color       = out_color_q;
  assign out_transparent = out_transparent_q;
  assign out_last        = out_last_q;

endmodule

`default_nettype wire

// File: tb/tb_texture_sampler.sv
//------------------------------------------------------------------------------
// Module   : tb_texture_sampler
// Purpose  : Scoreboard bench for texture_sampler with a registered-read RAM
//            model; honours TEX_SHADE_EN for the expected pixel colours.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_texture_sampler;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_tile;
  logic [3:0]  in_u;
  logic [3:0]  in_v;
  logic [1:0]  in_shade;
  logic        in_last;
  logic [21:0] raddr;
  logic [11:0] rcolor;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_color;
  logic        out_transparent;
  logic        out_last;

  texture_sampler dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_tile         (in_tile),
    .in_u            (in_u),
    .in_v            (in_v),
    .in_shade        (in_shade),
    .in_last         (in_last),
    .raddr           (raddr),
    .rcolor          (rcolor),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_color       (out_color),
    .out_transparent (out_transparent),
    .out_last        (out_last)
  );

  always #5 clk = ~clk;

  logic [11:0] mem [0:4095];
  always @(posedge clk) rcolor <= mem[raddr[11:0]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] color;
    logic        transp;
    logic        last;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   lat_mode   = 1'b0;
  bit   rand_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic int model_addr(input int tile, input int u, input int v);
    int row, col;
    row = tile / 4;
    col = tile % 4;
    return (row * 16 + v) * 64 + col * 16 + u;
  endfunction

  function automatic logic [11:0] model_color(input logic [11:0] t, input int s);
    logic [11:0] res;
    res = t;
`ifdef TEX_SHADE_EN
    for (int ch = 0; ch < 3; ch++) begin
      int c;
      c = int'(t[ch*4 +: 4]);
      res[ch*4 +: 4] = 4'((c * (4 - s)) / 4);
    end
`else
    if (s > 3) res = 12'h000;
`endif
    return res;
  endfunction

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send(input int tile, input int u, input int v, input int sh,
                      input bit last, input int exp_addr);
    int   waits;
    int   a;
    exp_t e;
    waits = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_tile  = 4'(tile);
    in_u     = 4'(u);
    in_v     = 4'(v);
    in_shade = 2'(sh);
    in_last  = last;
    #1;
    while (!in_ready) begin
      @(negedge clk);
      #1;
      waits++;
      if (waits > 200) begin
        chk("accept_timeout", 32'(waits), 32'd0);
        in_valid = 1'b0;
        return;
      end
    end
    a = (exp_addr >= 0) ? exp_addr : model_addr(tile, u, v);
    e.color  = model_color(mem[a], sh);
    e.transp = (mem[a] == 12'hF0F);
    e.last   = last;
    e.lat    = lat_mode;
    if (lat_mode) chk("stream_ready", 32'(waits), 32'd0);
    @(posedge clk);
    #1;
    e.acc = cyc;
    sb.push_back(e);
    chk("raddr", 32'(raddr), 32'(a));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    repeat (2) @(posedge clk);
  endtask

  // Monitor: picks out_ready for the coming edge, then checks what is offered.
  initial begin
    logic        prev_stall;
    logic [11:0] p_color;
    logic        p_transp, p_last;
    exp_t        e;
    prev_stall = 1'b0;
    p_color = '0; p_transp = 1'b0; p_last = 1'b0;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      out_ready = rand_ready ? 1'($urandom % 2) : 1'b1;
      #2;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stable_valid", 32'(out_valid), 32'd1);
          chk("stable_color", 32'(out_color), 32'(p_color));
          chk("stable_transp", 32'(out_transparent), 32'(p_transp));
          chk("stable_last", 32'(out_last), 32'(p_last));
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_pixel", 32'(out_valid), 32'd0);
          end else begin
            e = sb.pop_front();
            chk("color", 32'(out_color), 32'(e.color));
            chk("transparent", 32'(out_transparent), 32'(e.transp));
            chk("last", 32'(out_last), 32'(e.last));
            // Two edges after the accepting edge = third cycle after the request cycle.
            if (e.lat) chk("latency", 32'(cyc - e.acc), 32'd2);
          end
        end
        prev_stall = out_valid && !out_ready;
        p_color  = out_color;
        p_transp = out_transparent;
        p_last   = out_last;
      end
    end
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 12'($urandom);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_tile  = 4'd5;
    in_u     = 4'd3;
    in_v     = 4'd2;
    in_shade = 2'd0;
    in_last  = 1'b1;

    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_raddr", 32'(raddr), 32'd0);
      chk("rst_out_color", 32'(out_color), 32'd0);
    end
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);

    send(5, 3, 2, 0, 1'b0, 1171);
    send(15, 15, 15, 0, 1'b1, 4095);
    send(0, 0, 0, 0, 1'b0, 0);
    idle();
    drain();

    lat_mode = 1'b1;
    for (int i = 0; i < 64; i++)
      send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
           $urandom_range(0, 3), (i % 16) == 15, -1);
    idle();
    drain();
    lat_mode = 1'b0;

    rand_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      if ($urandom % 4 == 0) idle();
      send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
           $urandom_range(0, 3), ($urandom % 8) == 0, -1);
    end
    idle();
    drain();
    rand_ready = 1'b0;

    mem[model_addr(7, 1, 1)] = 12'hFFF;
    for (int s = 0; s < 4; s++) send(7, 1, 1, s, 1'b0, -1);
    idle();
    drain();

    mem[model_addr(2, 4, 4)] = 12'hF0F;
    mem[model_addr(3, 5, 5)] = 12'hF0E;
    send(2, 4, 4, 0, 1'b0, -1);
    send(3, 5, 5, 0, 1'b1, -1);
    idle();
    drain();

    for (int i = 0; i < 3; i++)
      send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
           $urandom_range(0, 3), 1'b1, -1);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_color", 32'(out_color), 32'd0);
    chk("midrst_transparent", 32'(out_transparent), 32'd0);
    chk("midrst_last", 32'(out_last), 32'd0);
    chk("midrst_raddr", 32'(raddr), 32'd0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    sb.delete();

    send(9, 6, 12, 1, 1'b1, -1);
    send(14, 2, 8, 2, 1'b0, -1);
    idle();
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
